// File: rtl/vp_ctrl_pkg.sv
// Shared control types for the vector processor decode/execute boundary:
// condition codes, flag bit positions, halt state and the registered control bundle.
package vp_ctrl_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ  = 4'b0000,
    COND_NE  = 4'b0001,
    COND_CS  = 4'b0010,
    COND_CC  = 4'b0011,
    COND_MI  = 4'b0100,
    COND_PL  = 4'b0101,
    COND_VS  = 4'b0110,
    COND_VC  = 4'b0111,
    COND_HI  = 4'b1000,
    COND_LS  = 4'b1001,
    COND_GE  = 4'b1010,
    COND_LT  = 4'b1011,
    COND_GT  = 4'b1100,
    COND_LE  = 4'b1101,
    COND_AL  = 4'b1110,
    COND_UNC = 4'b1111
  } cond_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } halt_state_e;

  // ALU control lives outside the bundle so the stage can keep its width parameterised
  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       stuck;
    logic [1:0] flagwrite;
    cond_e      cond;
  } ctrl_de_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: 4-bit condition code against {N,Z,C,V}.
module cond_check
  import vp_ctrl_pkg::*;
(
  input  cond_e       cond,
  input  logic [3:0]  flags,
  output logic        condpass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condpass = 1'b1;
    unique case (cond)
      COND_EQ:  condpass = z;
      COND_NE:  condpass = ~z;
      COND_CS:  condpass = c;
      COND_CC:  condpass = ~c;
      COND_MI:  condpass = n;
      COND_PL:  condpass = ~n;
      COND_VS:  condpass = v;
      COND_VC:  condpass = ~v;
      COND_HI:  condpass = c & ~z;
      COND_LS:  condpass = ~c | z;
      COND_GE:  condpass = (n == v);
      COND_LT:  condpass = (n != v);
      COND_GT:  condpass = ~z & (n == v);
      COND_LE:  condpass = z | (n != v);
      COND_AL:  condpass = 1'b1;
      COND_UNC: condpass = 1'b1;
      default:  condpass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Decode-to-execute pipeline register with NZCV flags, condition qualification
// of write/branch controls, and a sticky HALT state entered by a qualified Stuck op.
module cond_exec_stage
  import vp_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int FLAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 PCSrcD,
  input  logic                 RegWriteD,
  input  logic                 MemtoRegD,
  input  logic                 MemWriteD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic                 StuckD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [1:0]           FlagWriteD,
  input  logic [3:0]           CondD,
  input  logic [FLAG_W-1:0]    ALUFlagsE,
  output logic                 RegWriteE,
  output logic                 MemWriteE,
  output logic                 PCSrcE,
  output logic                 BranchTakenE,
  output logic                 MemtoRegE,
  output logic                 ALUSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 CondExE,
  output logic [FLAG_W-1:0]    FlagsE,
  output logic                 Halted
);

  ctrl_de_t               ctrl_d;
  ctrl_de_t               ctrl_reg;
  logic [ALUCTRL_W-1:0]   aluctrl_reg;
  logic                   valid_reg;
  logic [FLAG_W-1:0]      flags_reg;
  halt_state_e            state_reg, state_next;
  logic                   condpass;
  logic                   condex;
  logic                   qual;

  assign ctrl_d = '{
    pcsrc:     PCSrcD,
    regwrite:  RegWriteD,
    memtoreg:  MemtoRegD,
    memwrite:  MemWriteD,
    branch:    BranchD,
    alusrc:    ALUSrcD,
    stuck:     StuckD,
    flagwrite: FlagWriteD,
    cond:      cond_e'(CondD)
  };

  // A flush wins over a simultaneous stall so the hazard unit can always kill the slot
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_reg    <= '0;
      aluctrl_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (FlushE) begin
      ctrl_reg    <= '0;
      aluctrl_reg <= '0;
      valid_reg   <= 1'b0;
    end else if (!StallE) begin
      ctrl_reg    <= ctrl_d;
      aluctrl_reg <= ALUControlD;
      valid_reg   <= 1'b1;
    end
  end

  cond_check u_cond_check (
    .cond     (ctrl_reg.cond),
    .flags    (flags_reg[3:0]),
    .condpass (condpass)
  );

  assign condex = condpass & valid_reg;
  assign qual   = condex & (state_reg == RUN);

  // Flags commit at the end of the E cycle; the following instruction sees them
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_reg <= '0;
    end else if (!StallE && (state_reg == RUN) && condex) begin
      if (ctrl_reg.flagwrite[1])
        flags_reg[FLAG_N:FLAG_Z] <= ALUFlagsE[FLAG_N:FLAG_Z];
      if (ctrl_reg.flagwrite[0])
        flags_reg[FLAG_C:FLAG_V] <= ALUFlagsE[FLAG_C:FLAG_V];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= RUN;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if ((state_reg == RUN) && ctrl_reg.stuck && condex && !StallE)
      state_next = HALT;
  end

  assign RegWriteE    = ctrl_reg.regwrite & qual;
  assign MemWriteE    = ctrl_reg.memwrite & qual;
  assign PCSrcE       = ctrl_reg.pcsrc    & qual;
  assign BranchTakenE = ctrl_reg.branch   & qual;
  assign MemtoRegE    = ctrl_reg.memtoreg;
  assign ALUSrcE      = ctrl_reg.alusrc;
  assign ALUControlE  = aluctrl_reg;
  assign CondExE      = condex;
  assign FlagsE       = flags_reg;
  assign Halted       = (state_reg == HALT);

endmodule
